// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-byte decoder: make/break/E0/E1 sequences -> one key event per keystroke.
// Define ASCII_LUT_EN to register a set-2 -> ASCII translation with each event.
module ps2_key_decoder #(
    parameter int unsigned IGN_LEN = 7,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             evt_valid,
    output logic             evt_make,
    output logic             evt_repeat,
    output logic             evt_ext,
    output logic [7:0]       evt_code,
    output logic [7:0]       evt_ascii,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_seq
);

    localparam int unsigned IGN_W = $clog2(IGN_LEN + 1);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StIgn} state_e;

    state_e           state_q, state_d;
    logic [IGN_W-1:0] ign_q, ign_d;
    logic             emit, emit_make, emit_ext, err_set;
    logic             key_match;

    always_comb begin
        state_d   = state_q;
        ign_d     = ign_q;
        emit      = 1'b0;
        emit_make = 1'b0;
        emit_ext  = 1'b0;
        err_set   = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    case (in_data)
                        8'hE0: state_d = StExt;
                        8'hF0: state_d = StBrk;
                        8'hE1: begin
                            state_d = StIgn;
                            ign_d   = IGN_W'(IGN_LEN);
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: ;
                        default: begin
                            emit      = 1'b1;
                            emit_make = 1'b1;
                        end
                    endcase
                end
                StExt: begin
                    state_d = StIdle;
                    case (in_data)
                        8'hF0:        state_d = StExtBrk;
                        8'hE0, 8'hE1: err_set = 1'b1;
                        default: begin
                            emit      = 1'b1;
                            emit_make = 1'b1;
                            emit_ext  = 1'b1;
                        end
                    endcase
                end
                StBrk, StExtBrk: begin
                    state_d = StIdle;
                    if (in_data == 8'hE0 || in_data == 8'hF0 || in_data == 8'hE1) begin
                        err_set = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = (state_q == StExtBrk);
                    end
                end
                StIgn: begin
                    ign_d = ign_q - IGN_W'(1);
                    if (ign_q == IGN_W'(1)) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign key_match = key_held && (held_code == in_data) && (held_ext == emit_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            ign_q   <= '0;
        end else begin
            state_q <= state_d;
            ign_q   <= ign_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evt_valid  <= 1'b0;
            evt_make   <= 1'b0;
            evt_repeat <= 1'b0;
            evt_ext    <= 1'b0;
            evt_code   <= 8'h00;
            key_held   <= 1'b0;
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            press_cnt  <= '0;
            err_seq    <= 1'b0;
        end else begin
            evt_valid <= emit;
            if (emit) begin
                evt_make   <= emit_make;
                evt_ext    <= emit_ext;
                evt_code   <= in_data;
                evt_repeat <= emit_make && key_match;
                // Last-pressed key wins; a break only clears the key it names.
                if (emit_make && !key_match) begin
                    press_cnt <= press_cnt + CNT_W'(1);
                    key_held  <= 1'b1;
                    held_code <= in_data;
                    held_ext  <= emit_ext;
                end
                if (!emit_make && key_match) key_held <= 1'b0;
            end
            if (err_set) err_seq <= 1'b1;
        end
    end

`ifdef ASCII_LUT_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evt_ascii <= 8'h00;
        end else if (emit) begin
            evt_ascii <= emit_ext ? 8'h00 : to_ascii(in_data);
        end
    end
`else
    assign evt_ascii = 8'h00;
`endif

endmodule
